// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and
// restoring divide over WIDTH cycles, followed by one sign-fixup/commit cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             is_mult,
  input  logic             is_multu,
  input  logic             is_div,
  input  logic             is_divu,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic             is_result_hi,
  input  logic             is_result_lo,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg;
  logic [WIDTH-1:0] a_mag_reg, b_mag_reg, a_raw_reg;
  logic             div_op_reg, neg_q_reg, neg_r_reg, b_zero_reg;

  logic             start, accept, signed_op, a_neg, b_neg, div_req, div_ge;
  logic [WIDTH-1:0] a_mag_in, b_mag_in, q_fix, r_fix;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  assign start     = valid & (is_mult | is_multu | is_div | is_divu);
  assign busy      = (state_reg != IDLE);
  assign stall     = busy & valid & (start | hi_wen | lo_wen | is_result_hi | is_result_lo);
  assign accept    = (state_reg == IDLE) & start & ~cancel;
  assign signed_op = is_mult | is_div;
  assign div_req   = is_div | is_divu;
  assign a_neg     = signed_op & rs_data[WIDTH-1];
  assign b_neg     = signed_op & rt_data[WIDTH-1];
  assign a_mag_in  = a_neg ? -rs_data : rs_data;
  assign b_mag_in  = b_neg ? -rt_data : rt_data;

  // Multiply: {acc_hi, acc_lo} holds partial product over the shifting multiplier.
  assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, a_mag_reg} : '0);
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_mag_reg};
  assign div_ge    = (div_shift >= {1'b0, b_mag_reg});

  assign prod_fix  = neg_q_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
  assign q_fix     = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
  assign r_fix     = neg_r_reg ? -acc_hi_reg : acc_hi_reg;

  assign hi = hi_reg;
  assign lo = lo_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (cancel)                              state_next = IDLE;
        else if (count_reg == CW'(WIDTH - 1))    state_next = SIGN;
      end
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      a_raw_reg  <= '0;
      div_op_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_mag_reg  <= a_mag_in;
            b_mag_reg  <= b_mag_in;
            a_raw_reg  <= rs_data;
            div_op_reg <= div_req;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            b_zero_reg <= (rt_data == '0);
            count_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= div_req ? a_mag_in : b_mag_in;
          end
          if (valid & hi_wen & ~cancel) hi_reg <= rs_data;
          if (valid & lo_wen & ~cancel) lo_reg <= rs_data;
        end
        CALC: begin
          if (cancel) begin
            count_reg <= '0;
          end else begin
            count_reg <= count_reg + 1'b1;
            if (div_op_reg) begin
              acc_hi_reg <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_ge};
            end else begin
              acc_hi_reg <= mul_sum[WIDTH:1];
              acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
            end
          end
        end
        SIGN: begin
          count_reg <= '0;
          if (!cancel) begin
            if (!div_op_reg) begin
              hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
              lo_reg <= prod_fix[WIDTH-1:0];
            end else if (b_zero_reg) begin
              // Divide by zero reports the raw dividend, untouched by sign fixup.
              hi_reg <= a_raw_reg;
              lo_reg <= '1;
            end else begin
              hi_reg <= r_fix;
              lo_reg <= q_fix;
            end
          end
        end
        default: count_reg <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized scoreboard bench for muldiv_seq: driver pushes expected HI/LO,
// monitor pops and compares whenever the unit leaves its busy window.
module tb_muldiv_seq;
  localparam int W = 32;
  localparam int K_MULT = 0, K_MULTU = 1, K_DIV = 2, K_DIVU = 3;

  logic clk = 1'b0;
  logic reset, valid, is_mult, is_multu, is_div, is_divu;
  logic hi_wen, lo_wen, is_result_hi, is_result_lo, cancel;
  logic [W-1:0] rs_data, rt_data, hi, lo;
  logic busy, stall;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .valid(valid),
    .is_mult(is_mult), .is_multu(is_multu), .is_div(is_div), .is_divu(is_divu),
    .hi_wen(hi_wen), .lo_wen(lo_wen),
    .is_result_hi(is_result_hi), .is_result_lo(is_result_lo),
    .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // Reference model: returns {HI, LO} using plain 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input int kind, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_v, q, r;
    longint unsigned ua, ub, p;
    logic [31:0] uq, ur;
    sa = $signed(a);
    sb_v = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (kind)
      K_MULT:  begin q = sa * sb_v; return q; end
      K_MULTU: begin p = ua * ub;  return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (kind == K_DIV) begin
          q = sa / sb_v;
          r = sa % sb_v;
          return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_inputs();
    valid = 0; is_mult = 0; is_multu = 0; is_div = 0; is_divu = 0;
    hi_wen = 0; lo_wen = 0; is_result_hi = 0; is_result_lo = 0;
  endtask

  // Present an op (called just after a rising edge), wait out any stall,
  // record the expected result and return just after the accepting edge.
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input bit will_cancel, output int stall_cycles);
    logic [63:0] exp;
    int n = 0;
    valid = 1; rs_data = a; rt_data = b;
    is_mult = (kind == K_MULT); is_multu = (kind == K_MULTU);
    is_div = (kind == K_DIV);   is_divu = (kind == K_DIVU);
    @(negedge clk);
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    stall_cycles = n;
    if (stall) begin
      check("issue_timeout", 32'(stall), 32'd0);
    end else begin
      exp = will_cancel ? {hi_m, lo_m} : ref_op(kind, a, b);
      sb.push_back(exp);
      {hi_m, lo_m} = exp;
      $display("op kind=%0d a=%08h b=%08h cancel=%0d exp hi=%08h lo=%08h",
               kind, a, b, will_cancel, exp[63:32], exp[31:0]);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic cancel_after(input int k);
    repeat (k) begin @(posedge clk); #1; end
    cancel = 1;
    @(posedge clk); #1;
    cancel = 0;
  endtask

  // Monitor: a falling busy marks a commit (or an aborted op).
  initial begin
    logic [63:0] exp;
    bit prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          if (sb.size() == 0) begin
            check("unexpected_commit", 32'd1, 32'd0);
          end else begin
            exp = sb.pop_front();
            check("commit_hi", hi, exp[63:32]);
            check("commit_lo", lo, exp[31:0]);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    int cnt, sc, kind, k;
    logic [31:0] a, b;
    bit canc;

    reset = 1; cancel = 0; rs_data = '0; rt_data = '0;
    clear_inputs();
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(posedge clk); #1;

    // multu max x max, with busy window length
    issue(K_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, sc);
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check("multu_busy_cycles", 32'(cnt), 32'd33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    @(posedge clk); #1;

    issue(K_MULT, 32'hFFFF_FFFD, 32'd5, 0, sc);        wait_idle();
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);
    issue(K_DIV, 32'hFFFF_FFF9, 32'd2, 0, sc);         wait_idle();
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    issue(K_DIVU, 32'd7, 32'd0, 0, sc);                wait_idle();
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", hi, 32'h0000_0007);
    issue(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, sc); wait_idle();
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    // mfhi one cycle after accept: stalled until busy falls
    issue(K_MULT, 32'h1234_5678, 32'hFEDC_BA98, 0, sc);
    @(posedge clk); #1;
    valid = 1; is_result_hi = 1;
    cnt = 0;
    @(negedge clk);
    while (stall && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("mfhi_stall_cycles", 32'(cnt), 32'd32);
    check("mfhi_value", hi, hi_m);
    @(posedge clk); #1;
    clear_inputs();

    // back-to-back mult is held for the full busy window, then accepted
    issue(K_MULT, 32'h0000_0007, 32'hFFFF_FFFE, 0, sc);
    issue(K_MULTU, 32'hDEAD_BEEF, 32'h0000_1000, 0, sc);
    check("b2b_stall_cycles", 32'(sc), 32'd33);
    wait_idle();

    // mthi while idle, then divu 9/4
    valid = 1; hi_wen = 1; rs_data = 32'h1234_5678;
    @(posedge clk); #1;
    clear_inputs();
    hi_m = 32'h1234_5678;
    check("mthi_hi", hi, 32'h1234_5678);
    valid = 1; lo_wen = 1; rs_data = 32'hCAFE_F00D; cancel = 1;
    @(posedge clk); #1;
    clear_inputs(); cancel = 0;
    check("mtlo_cancel_lo", lo, lo_m);
    issue(K_DIVU, 32'd9, 32'd4, 0, sc); wait_idle();
    check("divu_9_4_hi", hi, 32'd1);
    check("divu_9_4_lo", lo, 32'd2);

    // cancel at iteration 10: no commit, busy drops right after
    issue(K_DIV, 32'h7654_3210, 32'h0000_0033, 1, sc);
    cancel_after(10);
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_hi", hi, hi_m);
    check("cancel_lo", lo, lo_m);
    @(posedge clk); #1;

    // randomized ops, some cancelled in CALC or SIGN
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a = rand_val();
      b = rand_val();
      canc = ($urandom_range(0, 5) == 0);
      issue(kind, a, b, canc, sc);
      if (canc) begin
        k = $urandom_range(0, 32);
        cancel_after(k);
      end
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();

    // reset at iteration 20 abandons the op and clears HI/LO at once
    issue(K_DIV, 32'h0BAD_CAFE, 32'h0000_0101, 0, sc);
    repeat (20) begin @(posedge clk); #1; end
    reset = 1;
    #1;
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    sb.delete();
    hi_m = '0; lo_m = '0;
    @(negedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    issue(K_MULTU, 32'd3, 32'd4, 0, sc); wait_idle();

    cnt = 0;
    while (sb.size() != 0 && cnt < 100) begin @(negedge clk); cnt++; end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
